button_input: RTL
=================

// Module: button_input
// PURPOSE
// Input-side conditioner for the chip dispenser front panel. It is the counterpart of the LED output drivers.
// Two raw push-buttons are synchronised to clk and debounced, then turned into clean levels and one-cycle events:
// press, release and long-press. The dispenser control FSM consumes these events; LED drivers run off the same 50 MHz clk.
// PARAMETERS
// DEBOUNCE_CYCLES  1000000   cycles raw input must be stable before a level change is accepted (20 ms @ 50 MHz); >=1
// LONG_CYCLES      50000000  cycles after press before btnN_long pulses (1 s @ 50 MHz); DEBOUNCE_CYCLES < LONG_CYCLES < 2^27
// ACTIVE_LOW       1         1: raw pin reads 0 when pressed; 0: raw pin reads 1 when pressed
// PORTS
// clk           in   1  system clock, 50 MHz
// rst           in   1  synchronous reset, active-high
// btn1_raw      in   1  button 1 pin, asynchronous, bouncing
// btn2_raw      in   1  button 2 pin, asynchronous, bouncing
// btn1_level    out  1  debounced state of button 1, 1 = pressed
// btn1_press    out  1  one-cycle pulse on an accepted press
// btn1_release  out  1  one-cycle pulse on an accepted release
// btn1_long     out  1  one-cycle pulse when held LONG_CYCLES after the press pulse
// btn2_level, btn2_press, btn2_release, btn2_long   out  1 each   same as button 1
// BEHAVIOUR
// - The two channels are identical and independent. Each channel has:
//   - a 2-flop synchroniser, normalised to active-high after polarity handling (s);
//   - a 27-bit debounce counter;
//   - a 27-bit long counter;
//   - a long_fired flag.
// - Reset (rst=1 at posedge): every output goes to 0, sync flops go to "not pressed", counters go to 0, long_fired goes to 0, FSM goes to RELEASED.
// - Channel FSM (all transitions on posedge clk):
//   - RELEASED: s=1 -> PRESS_WAIT, dcnt<=0.
//   - PRESS_WAIT:
//     - s=0 -> RELEASED. The glitch is rejected and no event is produced.
//     - else dcnt==DEBOUNCE_CYCLES-1 -> PRESSED, level<=1, press<=1 for exactly one cycle, lcnt<=0, long_fired<=0.
//     - else dcnt++.
//   - PRESSED: s=0 -> RELEASE_WAIT, dcnt<=0.
//   - RELEASE_WAIT:
//     - s=1 -> PRESSED. Bounce is rejected, level stays 1, and the long count continues.
//     - else dcnt==DEBOUNCE_CYCLES-1 -> RELEASED, level<=0, release<=1 for one cycle.
//     - else dcnt++.
// - Latency: with the raw input stable, press (or release) rises at clock edge DEBOUNCE_CYCLES+3. Edge 1 is the first edge that samples the new raw value.
// - Long press:
//   - lcnt increments every cycle while level=1 and long_fired=0.
//   - When lcnt==LONG_CYCLES-1: long<=1 for one cycle, long_fired<=1, lcnt holds.
//   - long therefore rises exactly LONG_CYCLES edges after the press edge, and fires at most once per press.
// - Simultaneous events:
//   - If release and long would assert on the same edge, release is asserted and long is suppressed.
//   - press and release can never be high in the same cycle.
// - The two channels may raise events in the same cycle. No arbitration is done.
// - Reset mid-operation:
//   - Any pending count is discarded.
//   - A button held through reset is treated as a new press: full debounce, then a fresh press pulse. No release pulse is generated for the aborted press.
// - Counters never wrap. dcnt is reset on every transition and bounded by DEBOUNCE_CYCLES. lcnt saturates at LONG_CYCLES-1.
// TESTING (bench parameters DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1)
// 1. btn1_raw 1->0, held -> btn1_press high for 1 cycle at edge 7; btn1_level=1 from edge 7; btn2 outputs stay 0.
// 2. btn1_raw low for 3 cycles, then high -> no press; btn1_level stays 0; FSM returns to RELEASED.
// 3. Pressed button, raw toggles high for 2 cycles then low again -> no release pulse; btn1_level stays 1.
// 4. Hold btn1 for 30 cycles after press -> btn1_long pulses once, 20 edges after the press edge; release -> one btn1_release, 7 edges after the raw rises.
// 5. Both raws fall on the same edge -> btn1_press and btn2_press pulse together at edge 7.
// 6. rst for 1 cycle while btn1 held and level=1 -> all outputs 0 on the next edge; btn1_press re-pulses 7 edges after rst deasserts; no btn1_release.

Source files
------------

// File: rtl/button_input.sv
// Front-panel push-button conditioner: two identical channels that synchronise,
// debounce and turn raw pins into a clean level plus press/release/long-press pulses.

module button_channel #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int CNT_W = 27;
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] dcnt_q;
  logic [CNT_W-1:0] lcnt_q;
  logic             long_fired_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             long_q;
  logic             raw_norm;
  logic             sync1_q;
  logic             s_q;

  // Normalise polarity before synchronising so "0" always means not pressed.
  assign raw_norm = ACTIVE_LOW ? ~raw_i : raw_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= raw_norm;
      s_q     <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RELEASED;
      dcnt_q       <= '0;
      lcnt_q       <= '0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;

      // Long-press timer runs off the debounced level, so release bounces do not restart it.
      if (level_q && !long_fired_q) begin
        if (lcnt_q == LONG_MAX) begin
          long_q       <= 1'b1;
          long_fired_q <= 1'b1;
        end else begin
          lcnt_q <= lcnt_q + CNT_ONE;
        end
      end

      case (state_q)
        RELEASED: begin
          if (s_q) begin
            state_q <= PRESS_WAIT;
            dcnt_q  <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s_q) begin
            state_q <= RELEASED;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEB_MAX) begin
            state_q      <= PRESSED;
            dcnt_q       <= '0;
            level_q      <= 1'b1;
            press_q      <= 1'b1;
            lcnt_q       <= '0;
            long_fired_q <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!s_q) begin
            state_q <= RELEASE_WAIT;
            dcnt_q  <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (s_q) begin
            state_q <= PRESSED;
            dcnt_q  <= '0;
          end else if (dcnt_q == DEB_MAX) begin
            state_q   <= RELEASED;
            dcnt_q    <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            // A release landing on the long-press edge wins over the long pulse.
            long_q    <= 1'b0;
          end else begin
            dcnt_q <= dcnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= RELEASED;
          dcnt_q  <= '0;
        end
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

module button_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic btn1_level,
  output logic btn1_press,
  output logic btn1_release,
  output logic btn1_long,
  output logic btn2_level,
  output logic btn2_press,
  output logic btn2_release,
  output logic btn2_long
);

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_ch1 (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (btn1_raw),
    .level_o  (btn1_level),
    .press_o  (btn1_press),
    .release_o(btn1_release),
    .long_o   (btn1_long)
  );

  button_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_ch2 (
    .clk      (clk),
    .rst      (rst),
    .raw_i    (btn2_raw),
    .level_o  (btn2_level),
    .press_o  (btn2_press),
    .release_o(btn2_release),
    .long_o   (btn2_long)
  );

endmodule
